// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (optional even parity) feeding a first-word-fall-through receive FIFO.
// Latency: a byte is at the FIFO head on the cycle after its stop-bit sample edge; RXD adds 2 sync cycles.
// Backpressure: o_rx_valid/i_rx_ready pop; a byte arriving while full with no pop is dropped and flags overrun.
//
// Ports:
//   i_clk, i_reset       - clock and synchronous active-high reset
//   i_rxd                - asynchronous serial input, idle high
//   o_rx_data/o_rx_valid - FIFO head byte and not-empty; i_rx_ready pops when o_rx_valid=1
//   o_frame_err          - sticky: stop bit sampled low
//   o_overrun            - sticky: byte arrived with FIFO full and no pop
//   o_parity_err         - sticky parity mismatch (only with UART_RX_PARITY_EN, else 0)
//   i_err_clr            - clears all sticky flags on the next edge (a same-cycle set wins)
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err,
    input  logic       i_err_clr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    // S_PARITY is only reachable when the parity option is built in.
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic            r_rxd_meta;
    logic            r_rxs;
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_par_bad;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_frame_err;
    logic            r_overrun;
    logic            r_parity_err;

    logic            w_stop_smp;
    logic            w_good;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;

    // Two-flop synchronizer; reset to the idle level so reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rxd_meta <= 1'b1;
            r_rxs      <= 1'b1;
        end else begin
            r_rxd_meta <= i_rxd;
            r_rxs      <= r_rxd_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_par_bad <= 1'b0;
                    if (!r_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF) begin
                        // Still low at mid start bit: genuine start; otherwise a glitch.
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt     <= '0;
                        // Even parity: the parity bit equals the XOR of the data bits.
                        r_par_bad <= r_rxs ^ (^r_shift);
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (r_cnt == C_FULL) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Push is decoded from the FSM registers so the FIFO captures the byte on the stop-sample edge itself.
    assign w_stop_smp = (r_state == S_STOP) && (r_cnt == C_FULL);
    assign w_good     = w_stop_smp && r_rxs && !r_par_bad;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_rx_ready && !w_empty;
    assign w_wr_en = w_good && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Sticky flags: a set event in the same cycle as i_err_clr takes priority.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_stop_smp && !r_rxs)          r_frame_err <= 1'b1;
            else if (i_err_clr)                r_frame_err <= 1'b0;
            if (w_good && w_full && !w_pop)    r_overrun <= 1'b1;
            else if (i_err_clr)                r_overrun <= 1'b0;
            if (w_stop_smp && r_par_bad)       r_parity_err <= 1'b1;
            else if (i_err_clr)                r_parity_err <= 1'b0;
        end
    end

    // The head byte is forced to zero while empty so stale storage never shows after reset.
    assign o_rx_data    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_rx_valid   = !w_empty;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives RXD frames at 115200 baud from a 25 MHz clock.
// Expected bytes go into a queue when a good frame is sent; a monitor pops and compares on each DUT pop.
// Checks reset state, latency window, FIFO ordering, overrun, framing, glitch rejection and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CLKS_PER_BIT = 217;
    localparam int FIFO_DEPTH   = 4;
    localparam int BIT_NS       = 8680;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       err_clr;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;

    uart_rx_fifo #(.CLKS_PER_BIT(CLKS_PER_BIT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rxd        (rxd),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .i_rx_ready   (rx_ready),
        .o_frame_err  (frame_err),
        .o_overrun    (overrun),
        .o_parity_err (parity_err),
        .i_err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a pop happens on the next posedge whenever valid & ready are seen here.
    always @(negedge clk) begin
        if (!reset && rx_valid === 1'b1 && rx_ready === 1'b1) begin
            logic [8:0] exp9;
            exp9 = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            checks++;
            assert ({1'b0, rx_data} === exp9) else begin
                errors++;
                $error("FAIL pop_data observed=0x%0h expected=0x%0h", rx_data, exp9);
            end
        end
    end

    // Reference model of the receive FIFO occupancy while no consumer is popping.
    task automatic expect_byte(input logic [7:0] b);
        if (!rx_ready && exp_q.size() >= FIFO_DEPTH) exp_ovr = 1'b1;
        else exp_q.push_back(b);
    endtask

    task automatic send_body(input logic [7:0] b, input int stretch_ns, input bit par_flip);
        rxd = 1'b0;
        #(BIT_NS + stretch_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        #(BIT_NS);
`endif
    endtask

    // A bad stop bit is held low only past its middle so the line recovers without a false start.
    task automatic send_stop(input bit stop_bad);
        if (stop_bad) begin
            rxd = 1'b0;
            #5000;
            rxd = 1'b1;
            #(BIT_NS - 5000);
        end else begin
            rxd = 1'b1;
            #(BIT_NS);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_bad, input bit par_flip);
        send_body(b, 0, par_flip);
        if (!stop_bad && !par_flip) expect_byte(b);
        send_stop(stop_bad);
    endtask

    task automatic pop_cycles(input int n);
        @(posedge clk); #1 rx_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] seq2 [5];
        seq2 = '{8'h2A, 8'h34, 8'h39, 8'h2F, 8'h30};
        rxd = 1'b1; reset = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_frame", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity", parity_err, 0);

        // Single byte with stretched start bit: must appear during the stop bit, not before.
        send_body(8'h34, 1000, 1'b0);
        check("t1_valid_before_stop", rx_valid, 0);
        expect_byte(8'h34);
        send_stop(1'b0);
        check("t1_valid", rx_valid, 1);
        check("t1_data", rx_data, 8'h34);
        pop_cycles(1);
        @(negedge clk);
        check("t1_valid_after_pop", rx_valid, 0);
        check("t1_flags", {parity_err, overrun, frame_err}, 0);

        // Back-to-back stream with the consumer always ready.
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(seq2[i], 1'b0, 1'b0);
        #(BIT_NS);
        rx_ready = 1'b0;
        check("t2_drained", exp_q.size(), 0);
        check("t2_flags", {parity_err, overrun, frame_err}, 0);

        // Five bytes into a four-deep FIFO with no consumer.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b0);
        check("t3_overrun", overrun, exp_ovr);
        check("t3_valid", rx_valid, 1);
        pop_cycles(8);
        @(negedge clk);
        check("t3_drained", exp_q.size(), 0);
        check("t3_empty", rx_valid, 0);
        pulse_clr();
        @(negedge clk);
        check("t3_overrun_clr", overrun, 0);
        exp_ovr = 1'b0;

        // Framing error then a good byte.
        send_byte(8'h55, 1'b1, 1'b0);
        #(BIT_NS);
        check("t4_frame", frame_err, 1);
        check("t4_valid", rx_valid, 0);
        send_byte(8'hA5, 1'b0, 1'b0);
        check("t4_good_valid", rx_valid, 1);
        check("t4_good_data", rx_data, 8'hA5);
        pop_cycles(1);
        pulse_clr();
        @(negedge clk);
        check("t4_frame_clr", frame_err, 0);

        // Short low glitch must be rejected silently.
        rxd = 1'b0;
        #2000;
        rxd = 1'b1;
        #(2 * BIT_NS);
        check("t5_valid", rx_valid, 0);
        check("t5_flags", {parity_err, overrun, frame_err}, 0);

        // Load state (one byte queued, frame error) then reset in the middle of bit 4 of 0xFF.
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        check("t6_pre_valid", rx_valid, 1);
        check("t6_pre_frame", frame_err, 1);
        rxd = 1'b0;
        #(BIT_NS);
        rxd = 1'b1;
        #(4 * BIT_NS + BIT_NS / 2);
        @(posedge clk); #1 reset = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #(5 * BIT_NS);
        check("t6_valid", rx_valid, 0);
        check("t6_data", rx_data, 0);
        check("t6_flags", {parity_err, overrun, frame_err}, 0);
        send_byte(8'h12, 1'b0, 1'b0);
        check("t6_next_valid", rx_valid, 1);
        check("t6_next_data", rx_data, 8'h12);
        pop_cycles(1);

`ifdef UART_RX_PARITY_EN
        // Wrong parity drops the byte; correct parity is accepted and the sticky flag stays.
        send_byte(8'h03, 1'b0, 1'b1);
        check("t7_parity", parity_err, 1);
        check("t7_drop", rx_valid, 0);
        send_byte(8'h03, 1'b0, 1'b0);
        check("t7_valid", rx_valid, 1);
        check("t7_data", rx_data, 8'h03);
        check("t7_parity_kept", parity_err, 1);
        pop_cycles(1);
`endif

        repeat (4) @(posedge clk);
        check("end_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receiver for the femto SoC UART RX path. It samples the asynchronous RXD line, deframes 8N1 characters (LSB first) at a fixed baud divisor, and pushes each good byte into a small first-word-fall-through FIFO. The CPU-side UART register logic pops the FIFO through a valid/ready handshake. Sticky error flags report framing errors and overruns.

Parameters:
CLKS_PER_BIT, 217, clk cycles per bit (25 MHz / 115200 baud); must be >= 8.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.

Ports:
clk  input  1  system clock, 25 MHz nominal
reset  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial input; idle high
rx_data  output  8  byte at the FIFO head; valid only while rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer pop; a pop occurs on a cycle where rx_valid & rx_ready
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte received while FIFO full and no pop
parity_err  output  1  sticky parity error (see Optional Feature); constant 0 otherwise
err_clr  input  1  clears all sticky flags on the next edge

Behaviour:
- Clocking: single clk domain. All state uses synchronous, active-high reset.
- Input synchronizer: rxd passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value rxs.
- Reset values: FIFO empty, rx_valid=0, rx_data=0, all error flags 0, FSM=IDLE, bit counter=0. A reset mid-frame abandons the frame and nothing is pushed.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rxs=0, go to START and clear the counter.
  - START: count CLKS_PER_BIT/2 cycles (integer division), then sample rxs at mid start bit.
    - rxs=0: go to DATA and clear the counter.
    - rxs=1: treat as a glitch and return to IDLE; no flag is set.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into a shift register, LSB first. After 8 bits, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample mid stop bit, then go straight to IDLE so a back-to-back start bit is detected.
    - rxs=1: push the byte.
    - rxs=0: set frame_err and drop the byte.
- Sampling tolerance: mid-bit sampling tolerates a start bit stretched by up to 0.4 bit period. The bench stretches it by 1000 ns.
- Push latency: a byte appears on rx_data with rx_valid=1 on the cycle after the stop-bit sample edge, if the FIFO was empty.
- FIFO:
  - First-word fall-through; read/write pointers carry log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full: pointers differ only in the MSB. Empty: pointers equal.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs the same cycle.
  - Otherwise the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - A pop with rx_valid=0 is ignored.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored and the push is accepted.
- Sticky flags: set by their events and cleared by err_clr. If err_clr and a set event occur in the same cycle, set wins.
- rx_data: holds the head byte and is stable while rx_valid=1 and no pop occurs.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: a PARITY state is added between DATA and STOP. It samples an even-parity bit at mid-bit.
  - On mismatch, the byte is dropped at STOP and parity_err is set.
  - If the stop bit is also low, frame_err is set as well.
- Undefined: 8N1 only, no PARITY state, parity_err tied to 0.

Test Plan:
- Reset, then send 0x34 at 8680 ns/bit with the start bit stretched 1000 ns -> rx_valid=1 one cycle after the stop sample, rx_data=0x34; pop clears rx_valid; all flags stay 0.
- Send 0x2A, 0x34, 0x39, 0x2F, 0x30 back to back, with rx_ready=1 held -> bytes popped in order, no flags set.
- Send 5 bytes (0x01..0x05) with rx_ready=0 -> popping yields 0x01..0x04, 0x05 is lost, overrun=1; err_clr -> overrun=0.
- Send 0x55 with the stop bit driven 0 -> frame_err=1, rx_valid stays 0; the next good byte 0xA5 is received correctly.
- Pulse rxd low for 2000 ns (less than half a bit) -> glitch rejected: no byte, no flags, FSM back in IDLE.
- Assert reset during bit 4 of 0xFF -> FIFO empty, flags 0; the next byte 0x12 is received correctly.
- With UART_RX_PARITY_EN: send 0x03 with parity 1 -> byte dropped, parity_err=1; resend 0x03 with parity 0 -> rx_data=0x03, parity_err unchanged.
